// File: rtl/demux_ch_sequencer_if.sv
// Handshake and demux-facing signals of the channel sequencer; the source side drives, the sequencer is the slave.
// ch_mask exists only when DEMUX_SEQ_MASK_EN is defined.
interface demux_ch_sequencer_if;
    logic       en;
    logic [1:0] mode;
    logic [2:0] fixed_ch;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic [2:0] s;
    logic       i;
    logic       busy;
    logic       frame_done;
`ifdef DEMUX_SEQ_MASK_EN
    logic [7:0] ch_mask;

    modport master (output en, mode, fixed_ch, in_valid, in_bit, ch_mask,
                    input  in_ready, s, i, busy, frame_done);
    modport slave  (input  en, mode, fixed_ch, in_valid, in_bit, ch_mask,
                    output in_ready, s, i, busy, frame_done);
`else
    modport master (output en, mode, fixed_ch, in_valid, in_bit,
                    input  in_ready, s, i, busy, frame_done);
    modport slave  (input  en, mode, fixed_ch, in_valid, in_bit,
                    output in_ready, s, i, busy, frame_done);
`endif
endinterface

// File: rtl/demux_ch_sequencer.sv
// Serial bit stream -> registered select/data for a 1:8 demux, FIXED channel or SCAN bursts; 1 cycle accept->i/s,
// in_ready only in SEND. Optional macro DEMUX_SEQ_MASK_EN adds a SCAN channel mask.
module demux_ch_sequencer #(
    parameter int BURST_LEN  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_ch_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_s, w_s_nxt;
    logic       r_i, w_i_nxt;
    logic       r_fd, w_fd_nxt;
    logic [3:0] r_bit_cnt, w_bit_nxt;
    logic [3:0] r_gap_cnt, w_gap_nxt;
    logic [2:0] r_cur_ch, w_cur_nxt;
    logic       r_scan, w_scan_nxt;

    logic       w_xfer;
    logic [2:0] w_first_ch;
    logic [2:0] w_next_ch;
    logic       w_wrap;
    logic       w_mask_empty;

    assign w_xfer = bus.in_valid && (r_state == S_SEND);

`ifdef DEMUX_SEQ_MASK_EN
    logic w_first_found;
    logic w_next_found;

    // Next enabled channel is searched cyclically above cur_ch; d == 8 lands back on cur_ch itself.
    always_comb begin
        w_first_ch    = 3'd0;
        w_next_ch     = r_cur_ch;
        w_first_found = 1'b0;
        w_next_found  = 1'b0;
        w_mask_empty  = (bus.ch_mask == 8'd0);
        for (int k = 0; k < 8; k++) begin
            if (bus.ch_mask[k] && !w_first_found) begin
                w_first_ch    = 3'(k);
                w_first_found = 1'b1;
            end
        end
        for (int d = 1; d <= 8; d++) begin
            if (bus.ch_mask[3'(r_cur_ch + 3'(d))] && !w_next_found) begin
                w_next_ch    = 3'(r_cur_ch + 3'(d));
                w_next_found = 1'b1;
            end
        end
        w_wrap = (w_next_ch <= r_cur_ch);
    end
`else
    assign w_first_ch   = 3'd0;
    assign w_next_ch    = r_cur_ch + 3'd1;
    assign w_wrap       = (r_cur_ch == 3'd7);
    assign w_mask_empty = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_i_nxt     = 1'b0;
        w_fd_nxt    = 1'b0;
        w_bit_nxt   = r_bit_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_cur_nxt   = r_cur_ch;
        w_scan_nxt  = r_scan;
        unique case (r_state)
            S_IDLE: begin
                if (bus.en) begin
                    if (bus.mode == 2'b00) begin
                        w_scan_nxt  = 1'b0;
                        w_cur_nxt   = bus.fixed_ch;
                        w_state_nxt = S_SEND;
                    end else if (!w_mask_empty) begin
                        w_scan_nxt  = 1'b1;
                        w_cur_nxt   = w_first_ch;
                        w_state_nxt = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_i_nxt   = bus.in_bit;
                    w_s_nxt   = r_cur_ch;
                    w_bit_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == BURST_LAST) begin
                        w_bit_nxt = 4'd0;
                        if (r_scan) begin
                            if (w_mask_empty) begin
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_cur_nxt   = w_next_ch;
                                w_fd_nxt    = w_wrap;
                                w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_SEND;
                            end
                        end
                        if (!bus.en) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_nxt   = 4'd0;
                    w_state_nxt = S_SEND;
                end else begin
                    w_gap_nxt = r_gap_cnt + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_s       <= 3'd0;
            r_i       <= 1'b0;
            r_fd      <= 1'b0;
            r_bit_cnt <= 4'd0;
            r_gap_cnt <= 4'd0;
            r_cur_ch  <= 3'd0;
            r_scan    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s       <= w_s_nxt;
            r_i       <= w_i_nxt;
            r_fd      <= w_fd_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_cur_ch  <= w_cur_nxt;
            r_scan    <= w_scan_nxt;
        end
    end

    assign bus.in_ready   = (r_state == S_SEND);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.s          = r_s;
    assign bus.i          = r_i;
    assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_demux_ch_sequencer.sv
// Scoreboard bench: the stimulus thread predicts each accepted bit's channel/frame flag from its index in the
// stream; a negedge monitor pops and compares whenever a bit is due, and checks idle outputs otherwise.
`timescale 1ns/1ps
module tb_demux_ch_sequencer;
    localparam int BL = 4;
    localparam int GC = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_ch_sequencer_if bus();
    demux_ch_sequencer #(.BURST_LEN(BL), .GAP_CYCLES(GC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [2:0] ch;
        logic       b;
        logic       fd;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    bit   mon_en = 1'b0;

    // Reference model: stream position of the run, enabled-channel list, pending gap cycles.
    bit         m_active = 1'b0;
    bit         m_scan   = 1'b0;
    bit         m_xfer   = 1'b0;
    int         m_n      = 0;
    int         m_gap_left = 0;
    logic [2:0] m_fixed  = 3'd0;
    logic [2:0] m_s      = 3'd0;
    int         m_list[8];
    int         m_len    = 8;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void build_list();
        m_len = 0;
        for (int k = 0; k < 8; k++) begin
`ifdef DEMUX_SEQ_MASK_EN
            if (bus.ch_mask[k]) begin
                m_list[m_len] = k;
                m_len++;
            end
`else
            m_list[m_len] = k;
            m_len++;
`endif
        end
    endfunction

    task automatic model_step();
        exp_t e;
        int   burst;
        int   pos;
        int   idx;
        m_xfer = 1'b0;
        if (!rst_n) begin
            m_active   = 1'b0;
            m_n        = 0;
            m_gap_left = 0;
            m_s        = 3'd0;
            sb_q.delete();
        end else if (!m_active) begin
            if (bus.en) begin
                build_list();
                m_gap_left = 0;
                m_n        = 0;
                if (bus.mode == 2'b00) begin
                    m_active = 1'b1;
                    m_scan   = 1'b0;
                    m_fixed  = bus.fixed_ch;
                end else if (m_len > 0) begin
                    m_active = 1'b1;
                    m_scan   = 1'b1;
                end
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (bus.in_valid) begin
            burst = m_n / BL;
            pos   = m_n % BL;
            e.b   = bus.in_bit;
            if (m_scan) begin
                idx  = burst % m_len;
                e.ch = 3'(m_list[idx]);
                e.fd = (pos == BL - 1) && (idx == m_len - 1);
            end else begin
                e.ch = m_fixed;
                e.fd = 1'b0;
            end
            sb_q.push_back(e);
            m_s    = e.ch;
            m_xfer = 1'b1;
            m_n++;
            if (pos == BL - 1) begin
                if (m_scan) m_gap_left = GC;
                if (!bus.en) begin
                    m_active   = 1'b0;
                    m_gap_left = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("in_ready", int'(bus.in_ready), int'(m_active && m_gap_left == 0));
            chk("busy", int'(bus.busy), int'(m_active));
            if (m_xfer) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got no expected entry, required one at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("s", int'(bus.s), int'(e.ch));
                    chk("i", int'(bus.i), int'(e.b));
                    chk("frame_done", int'(bus.frame_done), int'(e.fd));
                end
            end else begin
                chk("i_idle", int'(bus.i), 0);
                chk("fd_idle", int'(bus.frame_done), 0);
                chk("s_hold", int'(bus.s), int'(m_s));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        bus.en       = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 64 && m_active; c++) begin
            bus.in_bit = 1'($urandom);
            tick();
        end
        chk("drain_to_idle", int'(m_active), 0);
    endtask

    bit pattern[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        bit reached;
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.mode     = 2'b01;
        bus.fixed_ch = 3'd0;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
`ifdef DEMUX_SEQ_MASK_EN
        bus.ch_mask  = 8'hFF;
`endif
        tick();
        mon_en = 1'b1;
        repeat (3) tick();

        // Full SCAN frame of ones, then a little into the next frame.
        rst_n = 1'b1;
        repeat (8 * (BL + GC) + 3) tick();
        drain();

        // FIXED channel 5 with a known pattern.
        bus.mode     = 2'b00;
        bus.fixed_ch = 3'd5;
        bus.en       = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = pattern[k];
            tick();
        end
        drain();

        // Random valid stalls, random en drops and mode/fixed_ch churn while running.
        for (int r = 0; r < 6; r++) begin
            bus.en = 1'b1;
            repeat (150) begin
                bus.mode     = 2'($urandom_range(0, 3));
                bus.fixed_ch = 3'($urandom);
                bus.en       = ($urandom_range(0, 19) != 0);
                bus.in_valid = ($urandom_range(0, 99) < 70);
                bus.in_bit   = 1'($urandom);
                tick();
            end
            drain();
        end

        // Reset in the middle of a channel-6 burst.
        bus.mode     = 2'b01;
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        reached      = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            bus.in_bit = 1'($urandom);
            tick();
            reached = m_active && m_scan && (m_n == 6 * BL + 2);
        end
        chk("reach_ch6_midburst", int'(reached), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drain();

`ifdef DEMUX_SEQ_MASK_EN
        bus.ch_mask  = 8'b1010_0001;
        bus.mode     = 2'b01;
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3 * 3 * (BL + GC) + 2) begin
            bus.in_bit = 1'($urandom);
            tick();
        end
        drain();
        bus.ch_mask = 8'h00;
        bus.en      = 1'b1;
        repeat (10) tick();
        chk("mask_zero_idle", int'(bus.busy), 0);
        bus.en = 1'b0;
        tick();
`endif

        mon_en = 1'b0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
